// File: rtl/mode_counter_if.sv
// mode_counter_if: control and status bundle for mode_counter.
// The master drives controls and limits; the slave returns count and flags.
interface mode_counter_if #(
  parameter int N      = 8,
  parameter int STEP_W = 4
);
  logic              en;
  logic              load;
  logic              udi;
  logic [1:0]        mode;
  logic [N-1:0]      d_in;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      lo_lim;
  logic [N-1:0]      hi_lim;
  logic [N-1:0]      q_out;
  logic              tc;
  logic              dir_out;
  logic              done;
  logic              err;

  modport master (
    output en,
    output load,
    output udi,
    output mode,
    output d_in,
    output step,
    output lo_lim,
    output hi_lim,
    input  q_out,
    input  tc,
    input  dir_out,
    input  done,
    input  err
  );

  modport slave (
    input  en,
    input  load,
    input  udi,
    input  mode,
    input  d_in,
    input  step,
    input  lo_lim,
    input  hi_lim,
    output q_out,
    output tc,
    output dir_out,
    output done,
    output err
  );
endinterface

// File: rtl/mode_counter.sv
// mode_counter: windowed up/down counter with wrap, saturate,
// bounce and one-shot modes, terminal-count pulse and done flag.
module mode_counter #(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mode_counter_if.slave bus
);
  localparam int W = N + 1;

  localparam logic [1:0] M_WRAP = 2'b00;
  localparam logic [1:0] M_SAT  = 2'b01;
  localparam logic [1:0] M_BNC  = 2'b10;
  localparam logic [1:0] M_ONE  = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

  state_e       state_q;
  logic [N-1:0] q_q;
  logic         dir_q;
  logic         tc_q;
  logic         done_q;

  logic         err_w;
  logic         cnt_en_w;
  logic         outside_w;
  logic         up_w;
  logic [W-1:0] step_x;
  logic [W-1:0] q_x;
  logic [W-1:0] lo_x;
  logic [W-1:0] hi_x;
  logic [W-1:0] sum_w;
  logic [W-1:0] diff_w;
  logic         hit_hi_w;
  logic         over_hi_w;
  logic         hit_lo_w;
  logic         under_lo_w;
  logic         hit_w;
  logic         wrap_hit_w;
  logic [N-1:0] lim_w;
  logic [N-1:0] move_d;
  logic [N-1:0] sat_d;
  logic [N-1:0] wrap_d;
  logic [N-1:0] load_d;
  logic [N-1:0] clamp_d;

  // Widened arithmetic and boundary decisions for the current cycle
  always_comb begin
    err_w     = bus.lo_lim > bus.hi_lim;
    cnt_en_w  = bus.en && (bus.step != '0);
    outside_w = (q_q < bus.lo_lim) || (q_q > bus.hi_lim);
    clamp_d   = (q_q < bus.lo_lim) ? bus.lo_lim : bus.hi_lim;

    step_x = W'(bus.step);
    q_x    = {1'b0, q_q};
    lo_x   = {1'b0, bus.lo_lim};
    hi_x   = {1'b0, bus.hi_lim};
    sum_w  = q_x + step_x;
    diff_w = q_x - step_x;

    up_w = (bus.mode == M_BNC) ? dir_q : bus.udi;

    hit_hi_w   = sum_w >= hi_x;
    over_hi_w  = sum_w > hi_x;
    hit_lo_w   = diff_w[N] || (diff_w <= lo_x);
    under_lo_w = diff_w[N] || (diff_w < lo_x);

    lim_w      = up_w ? bus.hi_lim : bus.lo_lim;
    hit_w      = up_w ? hit_hi_w : hit_lo_w;
    wrap_hit_w = up_w ? over_hi_w : under_lo_w;
    move_d     = up_w ? sum_w[N-1:0] : diff_w[N-1:0];

    sat_d  = hit_w ? lim_w : move_d;
    wrap_d = move_d;
    if (wrap_hit_w) begin
      wrap_d = up_w ? bus.lo_lim : bus.hi_lim;
    end

    load_d = bus.d_in;
    if (bus.d_in < bus.lo_lim) begin
      load_d = bus.lo_lim;
    end else if (bus.d_in > bus.hi_lim) begin
      load_d = bus.hi_lim;
    end
  end

  // Count, direction, pulse and one-shot state machine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      q_q     <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (!err_w) begin
        if (bus.load) begin
          q_q     <= load_d;
          dir_q   <= bus.udi;
          done_q  <= 1'b0;
          state_q <= RUN;
        end else begin
          if (bus.mode != M_ONE) begin
            done_q  <= 1'b0;
            state_q <= RUN;
          end
          if (cnt_en_w) begin
            if (outside_w) begin
              q_q <= clamp_d;
            end else begin
              unique case (bus.mode)
                M_WRAP: begin
                  q_q   <= wrap_d;
                  dir_q <= up_w;
                  tc_q  <= wrap_hit_w;
                end
                M_SAT: begin
                  q_q   <= sat_d;
                  dir_q <= up_w;
                  tc_q  <= hit_w && (q_q != lim_w);
                end
                M_BNC: begin
                  q_q   <= sat_d;
                  dir_q <= hit_w ? ~up_w : up_w;
                  tc_q  <= hit_w;
                end
                M_ONE: begin
                  if (state_q == RUN) begin
                    q_q   <= sat_d;
                    dir_q <= up_w;
                    if (hit_w) begin
                      state_q <= DONE;
                      done_q  <= 1'b1;
                      tc_q    <= 1'b1;
                    end
                  end
                end
              endcase
            end
          end
        end
      end
    end
  end

  assign bus.q_out   = q_q;
  assign bus.tc      = tc_q;
  assign bus.dir_out = dir_q;
  assign bus.done    = done_q;
  assign bus.err     = err_w;

endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: randomized scoreboard bench for mode_counter
// against an integer reference model of the counting rules.
module tb_mode_counter;
  logic clk = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  mode_counter_if #(.N(8), .STEP_W(4)) ifc ();

  mode_counter #(.N(8), .STEP_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  typedef struct {
    int q;
    bit tc;
    bit dir;
    bit done;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  int mq    = 0;
  bit mdir  = 1'b1;
  bit mdone = 1'b0;

  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d @%0t", nm, got, want, $time);
    end
  endtask

  function automatic exp_t model(
    input bit ld, input bit e, input bit u,
    input int m, input int d, input int s,
    input int lo, input int hi
  );
    exp_t x;
    int   t;
    int   lim;
    bit   up;
    bit   hit;
    x.tc  = 1'b0;
    x.err = lo > hi;
    if (lo <= hi) begin
      if (ld) begin
        mq    = (d < lo) ? lo : ((d > hi) ? hi : d);
        mdir  = u;
        mdone = 1'b0;
      end else begin
        if (m != 3) mdone = 1'b0;
        if (e && s != 0) begin
          if (mq < lo) mq = lo;
          else if (mq > hi) mq = hi;
          else begin
            up  = (m == 2) ? mdir : u;
            t   = up ? mq + s : mq - s;
            lim = up ? hi : lo;
            hit = up ? (t >= hi) : (t <= lo);
            case (m)
              0: begin
                if (up ? (t > hi) : (t < lo)) begin
                  mq   = up ? lo : hi;
                  x.tc = 1'b1;
                end else mq = t;
                mdir = up;
              end
              1: begin
                if (hit) begin
                  x.tc = (mq != lim);
                  mq   = lim;
                end else mq = t;
                mdir = up;
              end
              2: begin
                if (hit) begin
                  mq   = lim;
                  mdir = !up;
                  x.tc = 1'b1;
                end else mq = t;
              end
              default: begin
                if (!mdone) begin
                  mdir = up;
                  if (hit) begin
                    mq    = lim;
                    mdone = 1'b1;
                    x.tc  = 1'b1;
                  end else mq = t;
                end
              end
            endcase
          end
        end
      end
    end
    x.q    = mq;
    x.dir  = mdir;
    x.done = mdone;
    return x;
  endfunction

  task automatic drive(
    input bit ld, input bit e, input bit u,
    input int m, input int d, input int s,
    input int lo, input int hi
  );
    @(negedge clk);
    ifc.load   = ld;
    ifc.en     = e;
    ifc.udi    = u;
    ifc.mode   = 2'(m);
    ifc.d_in   = 8'(d);
    ifc.step   = 4'(s);
    ifc.lo_lim = 8'(lo);
    ifc.hi_lim = 8'(hi);
    sb.push_back(model(ld, e, u, m, d, s, lo, hi));
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_q", int'(ifc.q_out), 0);
    chk("rst_mid_tc", int'(ifc.tc), 0);
    chk("rst_mid_dir", int'(ifc.dir_out), 1);
    chk("rst_mid_done", int'(ifc.done), 0);
    mq    = 0;
    mdir  = 1'b1;
    mdone = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: one expected entry per rising edge after stimulus
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("q_out", int'(ifc.q_out), x.q);
        chk("tc", int'(ifc.tc), int'(x.tc));
        chk("dir_out", int'(ifc.dir_out), int'(x.dir));
        chk("done", int'(ifc.done), int'(x.done));
        chk("err", int'(ifc.err), int'(x.err));
      end
    end
  end

  initial begin
    int lo;
    int hi;
    int m;
    int tmp;
    ifc.load   = 1'b0;
    ifc.en     = 1'b0;
    ifc.udi    = 1'b0;
    ifc.mode   = 2'b00;
    ifc.d_in   = '0;
    ifc.step   = '0;
    ifc.lo_lim = '0;
    ifc.hi_lim = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_q", int'(ifc.q_out), 0);
    chk("rst_tc", int'(ifc.tc), 0);
    chk("rst_dir", int'(ifc.dir_out), 1);
    chk("rst_done", int'(ifc.done), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // error window holds state and ignores load
    drive(1, 1, 1, 0, 25, 5, 30, 20);
    drive(0, 1, 1, 0, 25, 5, 30, 20);
    drive(0, 1, 1, 0, 0, 5, 0, 100);
    drive(0, 1, 1, 0, 0, 5, 0, 100);

    // wrap; load with en set must win
    drive(1, 1, 1, 0, 18, 3, 10, 20);
    repeat (5) drive(0, 1, 1, 0, 0, 3, 10, 20);
    reset_mid();

    // saturate down
    drive(1, 0, 0, 1, 9, 3, 5, 50);
    repeat (3) drive(0, 1, 0, 1, 0, 3, 5, 50);

    // bounce; udi is ignored while counting
    drive(1, 0, 1, 2, 5, 2, 0, 7);
    repeat (6) drive(0, 1, 0, 2, 0, 2, 0, 7);

    // one-shot, then reload clears done
    drive(1, 0, 1, 3, 250, 4, 0, 255);
    repeat (4) drive(0, 1, 1, 3, 0, 4, 0, 255);
    drive(1, 1, 1, 3, 3, 4, 0, 255);
    drive(0, 1, 1, 3, 0, 4, 0, 255);

    // leaving one-shot mode clears done without counting
    drive(1, 0, 1, 3, 250, 4, 0, 255);
    repeat (2) drive(0, 1, 1, 3, 0, 4, 0, 255);
    drive(0, 0, 1, 0, 0, 4, 0, 255);
    reset_mid();

    lo = 0;
    hi = 100;
    m  = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        lo = int'($urandom_range(0, 200));
        hi = lo + int'($urandom_range(0, 55));
        if ($urandom_range(0, 9) == 0) begin
          tmp = lo;
          lo  = hi;
          hi  = tmp;
        end
      end
      if ($urandom_range(0, 15) == 0) m = int'($urandom_range(0, 3));
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
            1'($urandom_range(0, 1)), m, int'($urandom_range(0, 255)),
            int'($urandom_range(0, 15)), lo, hi);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
